multdiv_param: RTL

- Parametrised iterative multiply/divide unit. Successor to the fixed 32-bit multdiv.
- Adds the following over the 32-bit unit:
  - configurable WIDTH;
  - runtime signed/unsigned mode;
  - remainder output;
  - busy status;
  - fully specified abort-and-restart ("interrupt") semantics when a new ctrl pulse arrives mid-operation.
- Sits beside the ALU in the processor execute stage. The stall logic waits on ready.

---
 rtl/multdiv_pkg.sv | 35 +++
 rtl/multdiv_step.sv | 40 ++++
 rtl/multdiv_param.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/multdiv_pkg.sv
// multdiv_pkg: shared state/op types and sign helpers
// for the parametrised iterative multiply/divide unit.
package multdiv_pkg;

    // Widest operand pair the sign helpers can handle (WIDTH <= 64).
    localparam int MAX_W = 128;

    typedef logic [MAX_W-1:0] wide_t;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        DONE
    } state_e;

    typedef enum logic {
        OP_MUL,
        OP_DIV
    } op_e;

    // Two's-complement negate when neg is set; callers truncate
    // the result to their own width, which keeps it width-generic.
    function automatic wide_t cneg(input wide_t v, input logic neg);
        return neg ? (~v + wide_t'(1)) : v;
    endfunction

    // Magnitude of a w-bit value, treated as signed only when sgn is set.
    function automatic wide_t mag(input wide_t v,
                                  input int unsigned w,
                                  input logic sgn);
        return cneg(v, sgn & (|(v & (wide_t'(1) << (w - 1)))));
    endfunction

endpackage

// File: rtl/multdiv_step.sv
// multdiv_step: one combinational iteration of the
// shift-add multiplier / restoring divider on the 2W accumulator.
module multdiv_step
    import multdiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  op_e                op_i,
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0]   opb_i,
    output logic [2*WIDTH-1:0] acc_o
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    // MUL: multiplier sits in the low half and is consumed LSB first;
    // the partial product (with its carry) shifts in from the top.
    // DIV: remainder in the high half, dividend/quotient in the low half;
    // trial subtract uses W+1 bits so the shifted remainder never overflows.
    always_comb begin
        sum   = {1'b0, acc_i[2*WIDTH-1:WIDTH]}
              + (acc_i[0] ? {1'b0, opb_i} : '0);
        diff  = acc_i[2*WIDTH-1:WIDTH-1] - {1'b0, opb_i};
        acc_o = '0;
        unique case (op_i)
            OP_MUL: begin
                acc_o = {sum, acc_i[WIDTH-1:1]};
            end
            OP_DIV: begin
                if (diff[WIDTH]) begin
                    acc_o = {acc_i[2*WIDTH-2:0], 1'b0};
                end else begin
                    acc_o = {diff[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
                end
            end
        endcase
    end

endmodule

// File: rtl/multdiv_param.sv
// multdiv_param: iterative signed/unsigned multiply/divide with
// abort-and-restart on any new start pulse and a one-cycle ready.
module multdiv_param
    import multdiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] operandA,
    input  logic [WIDTH-1:0] operandB,
    input  logic             ctrl_Mult,
    input  logic             ctrl_Div,
    input  logic             ctrl_signed,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] remainder,
    output logic             except,
    output logic             ready,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam int W2    = 2 * WIDTH;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    logic [W2-1:0]    acc_q;
    logic [W2-1:0]    acc_nx;
    logic [WIDTH-1:0] den_q;
    op_e              op_q;
    logic             sgn_q;
    logic             neg_q;
    logic             sa_q;
    logic             dz_q;

    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] rem_q;
    logic             exc_q;

    logic             start;
    logic             fin;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    logic [W2-1:0]    prod;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rmd;
    logic [WIDTH-1:0] fx_res;
    logic [WIDTH-1:0] fx_rem;
    logic             fx_exc;

    assign start = ctrl_Mult | ctrl_Div;

    // Operand sign capture and magnitude conversion at the start edge.
    always_comb begin
        a_neg = ctrl_signed & operandA[WIDTH-1];
        b_neg = ctrl_signed & operandB[WIDTH-1];
        a_mag = WIDTH'(mag(wide_t'(operandA), WIDTH, ctrl_signed));
        b_mag = WIDTH'(mag(wide_t'(operandB), WIDTH, ctrl_signed));
    end

    multdiv_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .op_i  (op_q),
        .acc_i (acc_q),
        .opb_i (den_q),
        .acc_o (acc_nx)
    );

    // Next state and counter; a start pulse preempts everything,
    // including the final iteration, so an aborted op never reports.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fin     = 1'b0;
        if (start) begin
            state_d = ctrl_Mult ? MUL : DIV;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
                MUL: begin
                    if (cnt_q == LAST) begin
                        state_d = DONE;
                        fin     = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                DIV: begin
                    if (dz_q || cnt_q == LAST) begin
                        state_d = DONE;
                        fin     = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and counter registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Sign fix-up and exception detection on the final accumulator value.
    // Signed divide overflow (MIN / -1) is the only case where a
    // non-negated quotient magnitude reaches 2^(W-1).
    always_comb begin
        prod   = W2'(cneg(wide_t'(acc_nx), neg_q));
        quo    = WIDTH'(cneg(wide_t'(acc_nx[WIDTH-1:0]), neg_q));
        rmd    = WIDTH'(cneg(wide_t'(acc_nx[W2-1:WIDTH]), sgn_q & sa_q));
        fx_res = '0;
        fx_rem = '0;
        fx_exc = 1'b0;
        if (dz_q) begin
            fx_exc = 1'b1;
        end else if (op_q == OP_MUL) begin
            fx_res = prod[WIDTH-1:0];
            if (sgn_q) begin
                fx_exc = prod[W2-1:WIDTH] != {WIDTH{prod[WIDTH-1]}};
            end else begin
                fx_exc = |prod[W2-1:WIDTH];
            end
        end else begin
            fx_res = quo;
            fx_rem = rmd;
            fx_exc = sgn_q & ~neg_q & acc_nx[WIDTH-1];
        end
    end

    // Operand capture on start, one iteration per cycle while busy.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc_q <= '0;
            den_q <= '0;
            op_q  <= OP_MUL;
            sgn_q <= 1'b0;
            neg_q <= 1'b0;
            sa_q  <= 1'b0;
            dz_q  <= 1'b0;
        end else if (start) begin
            op_q  <= ctrl_Mult ? OP_MUL : OP_DIV;
            sgn_q <= ctrl_signed;
            neg_q <= a_neg ^ b_neg;
            sa_q  <= a_neg;
            dz_q  <= ~ctrl_Mult & (operandB == '0);
            if (ctrl_Mult) begin
                acc_q <= {{WIDTH{1'b0}}, b_mag};
                den_q <= a_mag;
            end else begin
                acc_q <= {{WIDTH{1'b0}}, a_mag};
                den_q <= b_mag;
            end
        end else if (state_q == MUL || state_q == DIV) begin
            acc_q <= acc_nx;
        end
    end

    // Visible results only change when an op actually completes.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            result_q <= '0;
            rem_q    <= '0;
            exc_q    <= 1'b0;
        end else if (fin) begin
            result_q <= fx_res;
            rem_q    <= fx_rem;
            exc_q    <= fx_exc;
        end
    end

    assign result    = result_q;
    assign remainder = rem_q;
    assign except    = exc_q;
    assign ready     = (state_q == DONE);
    assign busy      = (state_q == MUL) || (state_q == DIV);

endmodule
